// File: rtl/qseq_pkg.sv
// qseq_pkg: state codes, LFSR constants and helpers shared by the quiz sequencer and display decoders
package qseq_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_READY    = 4'b0010,
        S_QUESTION = 4'b0011,
        S_INPUT    = 4'b0100,
        S_JUDGE    = 4'b0101
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [3:0] DIN_MAX   = 4'd9;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

    // Folds a nibble into 0..9
    function automatic logic [3:0] que_of(input logic [3:0] l);
        return l >= 4'd10 ? l - 4'd6 : l;
    endfunction

endpackage

// File: rtl/quiz_seq_btn_edge.sv
// btn_edge: optional debounce filter followed by a rising-edge detector
module btn_edge #(
    parameter bit DEBOUNCE  = 1'b0,
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic level;
    logic prev;

    generate
        if (DEBOUNCE) begin : g_db
            localparam int CW = $clog2(DB_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
            logic [CW-1:0] cnt;
            logic          filt;
            // The filtered level flips only after DB_CYCLES consecutive disagreeing samples
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt  <= '0;
                    filt <= 1'b0;
                end else if (sig == filt) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt  <= '0;
                    filt <= sig;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            assign level = filt;
        end else begin : g_raw
            assign level = sig;
        end
    endgenerate

    always_ff @(posedge clk) begin
        prev <= rst ? 1'b0 : level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/quiz_seq.sv
// quiz_seq: factorisation quiz sequencer producing STATE/QUE/DIN for the 7-segment decoders.
// Define QSEQ_DEBOUNCE_EN to debounce BTN before edge detection.
module quiz_seq
    import qseq_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int Q_TIME    = 3,
    parameter int IN_TIME   = 5,
    parameter int DB_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       BTN,
    output logic [3:0] STATE,
    output logic [3:0] QUE,
    output logic [3:0] DIN,
    output logic       CORRECT,
    output logic       DONE
);

`ifdef QSEQ_DEBOUNCE_EN
    localparam bit BTN_DB = 1'b1;
`else
    localparam bit BTN_DB = 1'b0;
`endif

    localparam int PW   = $clog2(TICK_DIV);
    localparam int TMAX = Q_TIME > IN_TIME ? Q_TIME : IN_TIME;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] Q_LAST   = TW'(Q_TIME - 1);
    localparam logic [TW-1:0] IN_LAST  = TW'(IN_TIME - 1);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] psc;
    logic [TW-1:0] tcnt;
    logic [7:0]    lfsr;
    logic          tick;
    logic          start_rise;
    logic          btn_rise;

    btn_edge #(.DEBOUNCE(1'b0), .DB_CYCLES(DB_CYCLES)) u_start (
        .clk (CLK),
        .rst (RST),
        .sig (START),
        .rise(start_rise)
    );

    btn_edge #(.DEBOUNCE(BTN_DB), .DB_CYCLES(DB_CYCLES)) u_btn (
        .clk (CLK),
        .rst (RST),
        .sig (BTN),
        .rise(btn_rise)
    );

    assign tick  = psc == PSC_LAST;
    assign STATE = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     state_nxt = start_rise ? S_READY : S_IDLE;
            S_READY:    state_nxt = tick ? S_QUESTION : S_READY;
            S_QUESTION: state_nxt = (tick && tcnt == Q_LAST) ? S_INPUT : S_QUESTION;
            S_INPUT:    state_nxt = (tick && tcnt == IN_LAST) ? S_JUDGE : S_INPUT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Timers restart on every state change so each phase is measured from its own entry
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            psc     <= '0;
            tcnt    <= '0;
            lfsr    <= LFSR_SEED;
            QUE     <= '0;
            DIN     <= '0;
            CORRECT <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state <= state_nxt;
            lfsr  <= lfsr_next(lfsr);
            psc   <= (state == S_IDLE || state_nxt != state || tick) ? '0 : psc + 1'b1;
            tcnt  <= (state == S_IDLE || state_nxt != state) ? '0 : tcnt + TW'(tick);
            DONE  <= state == S_JUDGE;
            if (state == S_JUDGE)
                CORRECT <= DIN == QUE;
            if (state == S_READY && tick)
                QUE <= que_of(lfsr[3:0]);
            if (state == S_QUESTION && state_nxt == S_INPUT)
                DIN <= '0;
            else if (state == S_INPUT && btn_rise && DIN != DIN_MAX)
                DIN <= DIN + 1'b1;
        end
    end

endmodule

// File: tb/tb_quiz_seq.sv
// tb_quiz_seq: directed self-checking bench for quiz_seq (TICK_DIV=4, Q_TIME=2, IN_TIME=6, DB_CYCLES=4)
module tb_quiz_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       btn = 1'b0;
    logic [3:0] state, que, din;
    logic       correct, done;
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    logic [7:0] m_lfsr, m_prev;

    logic [3:0] o_ready, o_ready_end, o_q, o_q_end, o_in, o_in_end, o_j, o_idle;
    logic [3:0] o_que, o_din_qend, o_din_entry, o_din_fin;
    logic       o_done, o_done_after, o_corr;
    int         exp_que, n_done;

    quiz_seq #(.TICK_DIV(4), .Q_TIME(2), .IN_TIME(6), .DB_CYCLES(4)) dut (
        .CLK(clk), .RST(rst), .START(start), .BTN(btn),
        .STATE(state), .QUE(que), .DIN(din), .CORRECT(correct), .DONE(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_prev <= m_lfsr;
    end

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Plays one game from IDLE; called at a negedge, returns at the negedge after the DONE pulse
    task automatic game(input bit rel, input int np, input int nq, input bit last);
        int n;
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        o_ready = state;
        repeat (3) @(negedge clk);
        o_ready_end = state;
        @(negedge clk);
        o_q = state;
        o_que = que;
        exp_que = (m_prev[3:0] >= 4'd10) ? int'(m_prev[3:0]) - 6 : int'(m_prev[3:0]);
        for (int c = 0; c < 8; c++) begin
            btn = (c % 2 == 0) && (c / 2 < nq);
            if (c == 7) begin
                o_q_end = state;
                o_din_qend = din;
            end
            @(negedge clk);
        end
        o_in = state;
        o_din_entry = din;
        n = rel ? exp_que + np : np;
        for (int c = 0; c < 24; c++) begin
            btn = ((c % 2 == 0) && (c / 2 < n)) || (last && c == 23);
            if (c == 23) o_in_end = state;
            @(negedge clk);
        end
        btn = 1'b0;
        o_j = state;
        o_din_fin = din;
        @(negedge clk);
        o_idle = state;
        o_done = done;
        o_corr = correct;
        @(negedge clk);
        o_done_after = done;
        n_done = done_cnt - d0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state !== 4'b0001) begin failures++; $display("FAIL reset_state got=%0h exp=1", state); end
        checks++; if (que !== 4'd0) begin failures++; $display("FAIL reset_que got=%0d exp=0", que); end
        checks++; if (din !== 4'd0) begin failures++; $display("FAIL reset_din got=%0d exp=0", din); end
        checks++; if ({correct, done} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {correct, done}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_phase_timing();
        game(1'b0, 0, 0, 1'b0);
        checks++; if ({o_ready, o_ready_end, o_q, o_q_end, o_in, o_in_end, o_j, o_idle} !== 32'h22334451) begin
            failures++; $display("FAIL phase_seq got=%h exp=22334451", {o_ready, o_ready_end, o_q, o_q_end, o_in, o_in_end, o_j, o_idle}); end
        checks++; if (int'(o_que) !== exp_que || exp_que > 9) begin failures++; $display("FAIL timing_que got=%0d exp=%0d", o_que, exp_que); end
        checks++; if (o_din_fin !== 4'd0) begin failures++; $display("FAIL timing_din got=%0d exp=0", o_din_fin); end
        checks++; if (o_corr !== (exp_que == 0)) begin failures++; $display("FAIL timing_correct got=%b exp=%b", o_corr, exp_que == 0); end
        checks++; if ({o_done, o_done_after} !== 2'b10 || n_done != 1) begin
            failures++; $display("FAIL timing_done got=%b%b count=%0d exp=10 count=1", o_done, o_done_after, n_done); end
    endtask

    task automatic test_answer_correct();
        game(1'b1, 0, 0, 1'b0);
        checks++; if (int'(o_que) !== exp_que || exp_que > 9) begin failures++; $display("FAIL right_que got=%0d exp=%0d", o_que, exp_que); end
        checks++; if (int'(o_din_fin) !== exp_que) begin failures++; $display("FAIL right_din got=%0d exp=%0d", o_din_fin, exp_que); end
        checks++; if (o_corr !== 1'b1) begin failures++; $display("FAIL right_correct got=%b exp=1", o_corr); end
        checks++; if ({o_done, o_done_after} !== 2'b10 || n_done != 1) begin
            failures++; $display("FAIL right_done got=%b%b count=%0d exp=10 count=1", o_done, o_done_after, n_done); end
    endtask

    task automatic test_answer_wrong();
        int exp_din;
        game(1'b1, 1, 0, 1'b0);
        exp_din = exp_que + 1 > 9 ? 9 : exp_que + 1;
        checks++; if (int'(o_que) !== exp_que) begin failures++; $display("FAIL wrong_que got=%0d exp=%0d", o_que, exp_que); end
        checks++; if (int'(o_din_fin) !== exp_din) begin failures++; $display("FAIL wrong_din got=%0d exp=%0d", o_din_fin, exp_din); end
        checks++; if (o_corr !== (exp_din == exp_que)) begin failures++; $display("FAIL wrong_correct got=%b exp=%b", o_corr, exp_din == exp_que); end
    endtask

    task automatic test_saturate();
        game(1'b0, 12, 0, 1'b0);
        checks++; if (o_din_fin !== 4'd9) begin failures++; $display("FAIL sat_din got=%0d exp=9", o_din_fin); end
        checks++; if (o_corr !== (exp_que == 9)) begin failures++; $display("FAIL sat_correct got=%b exp=%b", o_corr, exp_que == 9); end
    endtask

    task automatic test_question_ignore();
        game(1'b0, 0, 3, 1'b0);
        checks++; if (o_din_qend !== 4'd9) begin failures++; $display("FAIL qign_hold got=%0d exp=9", o_din_qend); end
        checks++; if (o_din_entry !== 4'd0) begin failures++; $display("FAIL qign_entry got=%0d exp=0", o_din_entry); end
        checks++; if (o_din_fin !== 4'd0) begin failures++; $display("FAIL qign_final got=%0d exp=0", o_din_fin); end
    endtask

    task automatic test_final_cycle();
        game(1'b0, 2, 0, 1'b1);
        checks++; if (o_din_fin !== 4'd3) begin failures++; $display("FAIL last_press got=%0d exp=3", o_din_fin); end
        checks++; if (o_j !== 4'b0101) begin failures++; $display("FAIL last_state got=%0h exp=5", o_j); end
    endtask

    task automatic test_rst_mid();
        int d0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            btn = (c % 2 == 0);
            @(negedge clk);
        end
        checks++; if ({state, din} !== 8'h45) begin failures++; $display("FAIL rstmid_pre got=%h exp=45", {state, din}); end
        rst = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        checks++; if ({state, din, que, done} !== 13'h0200) begin
            failures++; $display("FAIL rstmid_post got=%h/%0d/%0d/%b exp=1/0/0/0", state, din, que, done); end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (done_cnt != d0 || state !== 4'b0001) begin
            failures++; $display("FAIL rstmid_quiet got=%0d,%0h exp=%0d,1", done_cnt, state, d0); end
    endtask

    task automatic test_start_held();
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        repeat (80) @(negedge clk);
        checks++; if (done_cnt - d0 != 1 || state !== 4'b0001) begin
            failures++; $display("FAIL held_once got=%0d,%0h exp=1,1", done_cnt - d0, state); end
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checks++; if (state !== 4'b0010) begin failures++; $display("FAIL held_restart got=%0h exp=2", state); end
        start = 1'b0;
        repeat (45) @(negedge clk);
        checks++; if (done_cnt - d0 != 2 || state !== 4'b0001) begin
            failures++; $display("FAIL held_second got=%0d,%0h exp=2,1", done_cnt - d0, state); end
    endtask

`ifdef QSEQ_DEBOUNCE_EN
    task automatic test_debounce();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (din !== 4'd0) begin failures++; $display("FAIL db_glitch got=%0d exp=0", din); end
        @(negedge clk);
        btn = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (din !== 4'd0) begin failures++; $display("FAIL db_early got=%0d exp=0", din); end
        @(negedge clk);
        checks++; if (din !== 4'd1) begin failures++; $display("FAIL db_latency got=%0d exp=1", din); end
        @(negedge clk);
        btn = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (din !== 4'd1) begin failures++; $display("FAIL db_once got=%0d exp=1", din); end
        repeat (10) @(negedge clk);
        checks++; if ({state, din} !== 8'h11) begin failures++; $display("FAIL db_end got=%h exp=11", {state, din}); end
    endtask
`endif

    initial begin
        test_reset();
        test_phase_timing();
`ifdef QSEQ_DEBOUNCE_EN
        test_debounce();
`else
        test_answer_correct();
        test_answer_wrong();
        test_saturate();
        test_question_ignore();
        test_final_cycle();
`endif
        test_rst_mid();
        test_start_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
